// File: rtl/trade_report_tx.sv
// Execution-report transmitter: queues approved trades and serialises
// each one as a 7-byte frame (SOF, SEQ, price, qty, buy, sell, CHK).
module trade_report_tx #(
    parameter int         DEPTH    = 8,
    parameter int         ADDR_W   = 3,
    parameter logic [7:0] SOF_BYTE = 8'hA5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              TRADE_APPROVED,
    input  logic [7:0]        APPR_PRICE,
    input  logic [7:0]        APPR_QTY,
    input  logic [7:0]        APPR_BUY_ID,
    input  logic [7:0]        APPR_SELL_ID,
    output logic [7:0]        TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    output logic [ADDR_W:0]   FIFO_COUNT,
    output logic [15:0]       DROP_COUNT,
    output logic              OVERFLOW
);

    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_SEQ, S_PRICE, S_QTY, S_BUY, S_SELL, S_CHK
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [15:0]       drop_q, drop_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        seq_q, seq_d;
    logic [7:0]        price_q, price_d;
    logic [7:0]        qty_q, qty_d;
    logic [7:0]        buy_q, buy_d;
    logic [7:0]        sell_q, sell_d;
    logic [7:0]        chk_q, chk_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              full, push, drop, pop, hs;
    logic [31:0]       head;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot
    assign full = (count_q == (ADDR_W+1)'(DEPTH));
    assign push = TRADE_APPROVED && !full;
    assign drop = TRADE_APPROVED && full;
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign hs   = tx_valid_q && TX_READY;
    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= {APPR_PRICE, APPR_QTY, APPR_BUY_ID, APPR_SELL_ID};
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            ovf_q      <= 1'b0;
            seq_q      <= '0;
            price_q    <= '0;
            qty_q      <= '0;
            buy_q      <= '0;
            sell_q     <= '0;
            chk_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            seq_q      <= seq_d;
            price_q    <= price_d;
            qty_q      <= qty_d;
            buy_q      <= buy_d;
            sell_q     <= sell_d;
            chk_q      <= chk_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (pop) state_d = S_SOF;
            S_SOF:   if (hs) state_d = S_SEQ;
            S_SEQ:   if (hs) state_d = S_PRICE;
            S_PRICE: if (hs) state_d = S_QTY;
            S_QTY:   if (hs) state_d = S_BUY;
            S_BUY:   if (hs) state_d = S_SELL;
            S_SELL:  if (hs) state_d = S_CHK;
            S_CHK:   if (hs) state_d = S_IDLE;
        endcase
    end

    // Each state presents its own byte; a handshake preloads the next one
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        seq_d      = seq_q;
        price_d    = price_q;
        qty_d      = qty_q;
        buy_d      = buy_q;
        sell_d     = sell_q;
        chk_d      = chk_q;
        unique case (state_q)
            S_IDLE: begin
                tx_valid_d = 1'b0;
                if (pop) begin
                    {price_d, qty_d, buy_d, sell_d} = head;
                    chk_d = seq_q ^ head[31:24] ^ head[23:16] ^ head[15:8] ^ head[7:0];
                    tx_data_d  = SOF_BYTE;
                    tx_valid_d = 1'b1;
                end
            end
            S_SOF:   if (hs) tx_data_d = seq_q;
            S_SEQ:   if (hs) tx_data_d = price_q;
            S_PRICE: if (hs) tx_data_d = qty_q;
            S_QTY:   if (hs) tx_data_d = buy_q;
            S_BUY:   if (hs) tx_data_d = sell_q;
            S_SELL:  if (hs) tx_data_d = chk_q;
            S_CHK: begin
                if (hs) begin
                    tx_valid_d = 1'b0;
                    seq_d      = seq_q + 8'd1;
                end
            end
        endcase
    end

    assign TX_DATA    = tx_data_q;
    assign TX_VALID   = tx_valid_q;
    assign FIFO_COUNT = count_q;
    assign DROP_COUNT = drop_q;
    assign OVERFLOW   = ovf_q;

endmodule

// File: doc/trade_report_tx.md
Name: trade_report_tx

Overview:
- Downstream stage of the pre-trade risk check. Captures every approved trade (approved flag, price, quantity, buy ID, sell ID) into a small FIFO.
- Serialises each trade as a fixed 7-byte execution-report frame on a valid/ready byte stream. That stream feeds the UART/host link.
- Decouples single-cycle approval pulses from a back-pressured output link. Counts trades lost to overflow.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- ADDR_W, 3, log2(DEPTH).
- SOF_BYTE, 8'hA5, start-of-frame marker byte.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- TRADE_APPROVED  in  1  one-cycle strobe: approved trade present on the APPR_* inputs.
- APPR_PRICE  in  8  approved trade price.
- APPR_QTY  in  8  approved trade quantity.
- APPR_BUY_ID  in  8  buyer ID.
- APPR_SELL_ID  in  8  seller ID.
- TX_DATA  out  8  current frame byte (registered).
- TX_VALID  out  1  TX_DATA valid (registered).
- TX_READY  in  1  sink accepts the byte when TX_VALID and TX_READY are both high at a rising edge.
- FIFO_COUNT  out  ADDR_W+1  entries currently queued.
- DROP_COUNT  out  16  trades dropped on full FIFO; saturates at 16'hFFFF.
- OVERFLOW  out  1  sticky; set on the first drop, cleared only by RESET.

Behaviour:
- Reset, asynchronous and applied immediately, including mid-frame:
  - TX_VALID=0, TX_DATA=0.
  - FIFO emptied, FIFO_COUNT=0.
  - DROP_COUNT=0, OVERFLOW=0.
  - Sequence counter SEQ=0.
  - FSM to IDLE.
  - A frame in progress is abandoned; nothing is resumed after reset.
- FIFO entry = {price, qty, buy, sell}, 32 bits.
- Push: TRADE_APPROVED=1 and FIFO not full, where "full" is the count registered before the edge.
- Push when full:
  - Trade is discarded.
  - DROP_COUNT increments (saturating) and OVERFLOW sets.
  - This applies even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: both happen, FIFO_COUNT unchanged.
- Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE -> SOF, SEQ, PRICE, QTY, BUY, SELL, CHK.
  - IDLE: TX_VALID=0. If FIFO_COUNT!=0, pop the head into frame registers and compute CHK = SEQ^price^qty^buy^sell. At the same edge, drive TX_DATA=SOF_BYTE, TX_VALID=1, and go to SOF.
  - Each byte state holds TX_DATA/TX_VALID stable until a handshake. On handshake, load the next byte and advance.
  - Byte order: SOF_BYTE, SEQ, price, qty, buy, sell, CHK.
  - CHK handshake: TX_VALID=0, SEQ increments (8-bit, 255 wraps to 0), return to IDLE.
  - This gives a minimum of one idle cycle between frames, so one frame costs 8 cycles minimum with TX_READY tied high.
- Latency: with an empty FIFO and the FSM in IDLE, TRADE_APPROVED sampled at edge N gives TX_VALID=1 with SOF after edge N+1 (visible in cycle N+2).
- TX_VALID never drops without a handshake except on reset.
- Dropped trades consume no sequence number.
- TX_READY is ignored while TX_VALID=0.
- Trades are reported strictly in arrival order.
- Frame contents are latched at pop; later inputs cannot alter a frame in flight.

Test Plan:
- Reset, then one trade (price 0x32, qty 0x0A, buy 0x01, sell 0x02) with TX_READY=1 -> bytes A5 00 32 0A 01 02 3B on consecutive cycles. TX_VALID first high 2 cycles after the strobe. FIFO_COUNT returns to 0.
- Same trade with TX_READY toggling 1,0,0,1,... -> identical byte sequence. TX_DATA held stable during stalls; no byte duplicated or skipped.
- Three back-to-back strobes, TX_READY=1 -> three frames with SEQ 00, 01, 02. Exactly one TX_VALID=0 cycle between frames. Checksums correct.
- TX_READY=0, 10 strobes on consecutive cycles, DEPTH=8:
  - First trade popped into the frame; 8 trades queued.
  - FIFO_COUNT=8, DROP_COUNT=1, OVERFLOW=1.
  - Then TX_READY=1 -> 9 frames, SEQ 00..08, in order.
- Preload SEQ to 0xFF by sending 255 frames, then send 2 more -> SEQ fields FF then 00.
- Assert RESET mid-frame during the QTY byte -> TX_VALID=0 immediately (asynchronously), FIFO_COUNT=0. After release, the next trade emits SEQ=00.
